// File: rtl/wb_grf_pkg.sv
// Shared decode constants, writeback-source encoding and load-extension helper
// for the writeback stage and register file.
package wb_grf_pkg;

    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MFLO    = 6'b010010;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [4:0] RS_MF      = 5'b00000;

    typedef enum logic [2:0] {
        WB_ALU = 3'd0,
        WB_DM  = 3'd1,
        WB_MDU = 3'd2,
        WB_CP0 = 3'd3,
        WB_PC8 = 3'd4
    } wb_src_e;

    function automatic wb_src_e wb_decode(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] fn;
        wb_src_e    src;
        op = instr[31:26];
        fn = instr[5:0];
        case (op)
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: src = WB_DM;
            OP_JAL:                              src = WB_PC8;
            OP_COP0: src = (instr[25:21] == RS_MF) ? WB_CP0 : WB_ALU;
            OP_SPECIAL: begin
                case (fn)
                    FN_MFHI, FN_MFLO: src = WB_MDU;
                    FN_JALR:          src = WB_PC8;
                    default:          src = WB_ALU;
                endcase
            end
            default: src = WB_ALU;
        endcase
        return src;
    endfunction

    // Halfword offsets only look at off[1]; misaligned halves never reach here.
    function automatic logic [31:0] load_ext(input logic [5:0] op,
                                             input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   res = {{24{b[7]}}, b};
            OP_LBU:  res = {24'd0, b};
            OP_LH:   res = {{16{h[15]}}, h};
            OP_LHU:  res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_grf_sel.sv
// Writeback source decoder and load-extend unit; purely combinational.
module wb_sel
    import wb_grf_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] mdu_i,
    input  logic [31:0] dm_i,
    input  logic [31:0] cp0_i,
    input  logic [31:0] pc8_i,
    output logic [31:0] wd_o
);

    wb_src_e src_s;

    // Select the writeback datum from the decoded source.
    always_comb begin
        src_s = wb_decode(instr_i);
        case (src_s)
            WB_DM:   wd_o = load_ext(instr_i[31:26], alu_i[1:0], dm_i);
            WB_MDU:  wd_o = mdu_i;
            WB_CP0:  wd_o = cp0_i;
            WB_PC8:  wd_o = pc8_i;
            WB_ALU:  wd_o = alu_i;
            default: wd_o = alu_i;
        endcase
    end

endmodule

// File: rtl/wb_grf.sv
// Writeback stage plus 32x32 general register file with write-through bypass
// and a retired-instruction counter.
module wb_grf
    import wb_grf_pkg::*;
#(
    parameter bit ENABLE_BYPASS = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [31:0]      Instr_WB,
    input  logic [31:0]      ALU_Out_WB,
    input  logic [31:0]      MDU_Out_WB,
    input  logic [31:0]      DM_Out_WB,
    input  logic [31:0]      CP0_Out_WB,
    input  logic [31:0]      PC8_Out_WB,
    input  logic [31:0]      PC_WB,
    input  logic [4:0]       Rx_WB,
    input  logic [4:0]       A1,
    input  logic [4:0]       A2,
    output logic [31:0]      RD1,
    output logic [31:0]      RD2,
    output logic             WE,
    output logic [4:0]       WA,
    output logic [31:0]      WD,
    output logic [CNT_W-1:0] Retired
);

    logic [31:0]      rf_q [0:31];
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] retired_d;
    logic [31:0]      wd_s;
    logic             we_s;
    logic [31:0]      stored1_s;
    logic [31:0]      stored2_s;

    // PC is trace-only and has no role in the datapath.
    logic unused_pc_s;
    assign unused_pc_s = &{1'b0, PC_WB};

    wb_sel u_sel (
        .instr_i (Instr_WB),
        .alu_i   (ALU_Out_WB),
        .mdu_i   (MDU_Out_WB),
        .dm_i    (DM_Out_WB),
        .cp0_i   (CP0_Out_WB),
        .pc8_i   (PC8_Out_WB),
        .wd_o    (wd_s)
    );

    assign we_s    = (Rx_WB != 5'd0);
    assign WE      = we_s;
    assign WA      = Rx_WB;
    assign WD      = wd_s;
    assign Retired = retired_q;

    // Retired count advances on every non-bubble instruction.
    always_comb begin
        if (Instr_WB != 32'd0) begin
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_d = retired_q;
        end
    end

    // Register file and counter; reset wins over a same-edge write.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
            retired_q <= '0;
        end else begin
            if (we_s) begin
                rf_q[Rx_WB] <= wd_s;
            end
            retired_q <= retired_d;
        end
    end

    // Read ports: entry 0 is hardwired zero, a matching write may bypass storage.
    always_comb begin
        stored1_s = (A1 == 5'd0) ? 32'd0 : rf_q[A1];
        stored2_s = (A2 == 5'd0) ? 32'd0 : rf_q[A2];
        if (ENABLE_BYPASS && we_s && (A1 == Rx_WB)) begin
            RD1 = wd_s;
        end else begin
            RD1 = stored1_s;
        end
        if (ENABLE_BYPASS && we_s && (A2 == Rx_WB)) begin
            RD2 = wd_s;
        end else begin
            RD2 = stored2_s;
        end
    end

endmodule

// File: tb/tb_wb_grf.sv
// Scoreboard bench for wb_grf: stimulus queues expected values, a negedge
// monitor pops and compares them against the live DUT outputs.
module tb_wb_grf;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] Instr_WB, ALU_Out_WB, MDU_Out_WB, DM_Out_WB, CP0_Out_WB, PC8_Out_WB, PC_WB;
    logic [4:0]  Rx_WB, A1, A2;
    logic [31:0] RD1, RD2, WD, Retired;
    logic        WE;
    logic [4:0]  WA;
    logic [31:0] RD1_nb, RD2_nb, WD_nb;
    logic        WE_nb;
    logic [4:0]  WA_nb;
    logic [1:0]  Ret_nb;

    always #5 Clk = ~Clk;

    wb_grf #(.ENABLE_BYPASS(1'b1), .CNT_W(32)) dut (
        .Clk(Clk), .Rst(Rst), .Instr_WB(Instr_WB), .ALU_Out_WB(ALU_Out_WB),
        .MDU_Out_WB(MDU_Out_WB), .DM_Out_WB(DM_Out_WB), .CP0_Out_WB(CP0_Out_WB),
        .PC8_Out_WB(PC8_Out_WB), .PC_WB(PC_WB), .Rx_WB(Rx_WB), .A1(A1), .A2(A2),
        .RD1(RD1), .RD2(RD2), .WE(WE), .WA(WA), .WD(WD), .Retired(Retired)
    );

    wb_grf #(.ENABLE_BYPASS(1'b0), .CNT_W(2)) dut_nb (
        .Clk(Clk), .Rst(Rst), .Instr_WB(Instr_WB), .ALU_Out_WB(ALU_Out_WB),
        .MDU_Out_WB(MDU_Out_WB), .DM_Out_WB(DM_Out_WB), .CP0_Out_WB(CP0_Out_WB),
        .PC8_Out_WB(PC8_Out_WB), .PC_WB(PC_WB), .Rx_WB(Rx_WB), .A1(A1), .A2(A2),
        .RD1(RD1_nb), .RD2(RD2_nb), .WE(WE_nb), .WA(WA_nb), .WD(WD_nb), .Retired(Ret_nb)
    );

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;

    localparam int S_WD = 0, S_WE = 1, S_WA = 2, S_RD1 = 3, S_RD2 = 4,
                   S_RET = 5, S_RD1NB = 6, S_RETNB = 7;

    function automatic logic [31:0] observe(int sig);
        case (sig)
            S_WD:    return WD;
            S_WE:    return {31'd0, WE};
            S_WA:    return {27'd0, WA};
            S_RD1:   return RD1;
            S_RD2:   return RD2;
            S_RET:   return Retired;
            S_RD1NB: return RD1_nb;
            S_RETNB: return {30'd0, Ret_nb};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic exp_v(input string name, input int sig, input logic [31:0] v);
        exp_t e;
        e.name = $sformatf("s%0d_%s", step_no, name);
        e.sig  = sig;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    // Monitor: drain everything queued for this cycle at the falling edge.
    always @(negedge Clk) begin
        exp_t        e;
        logic [31:0] got;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = observe(e.sig);
            n_tests++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
            end
        end
    end

    task automatic step(input logic [31:0] instr, input logic [4:0] rx,
                        input logic [31:0] alu, input logic [31:0] dm,
                        input logic [31:0] mdu, input logic [31:0] cp0,
                        input logic [31:0] pc8, input logic [4:0] a1,
                        input logic [4:0] a2, input logic rst);
        @(posedge Clk);
        #1;
        step_no++;
        Instr_WB = instr; Rx_WB = rx; ALU_Out_WB = alu; DM_Out_WB = dm;
        MDU_Out_WB = mdu; CP0_Out_WB = cp0; PC8_Out_WB = pc8;
        A1 = a1; A2 = a2; Rst = rst; PC_WB = 32'h0000_3000 + 32'(step_no * 4);
    endtask

    initial begin
        Rst = 1'b0; Instr_WB = 32'd0; Rx_WB = 5'd0; ALU_Out_WB = 32'd0; DM_Out_WB = 32'd0;
        MDU_Out_WB = 32'd0; CP0_Out_WB = 32'd0; PC8_Out_WB = 32'd0; PC_WB = 32'd0;
        A1 = 5'd0; A2 = 5'd0;
        repeat (2) @(posedge Clk);

        step(32'h8C00_0000, 5'd5, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0, 1'b1);
        exp_v("lw_we", S_WE, 32'd1); exp_v("lw_wa", S_WA, 32'd5);
        exp_v("lw_wd", S_WD, 32'hDEAD_BEEF); exp_v("bypass_rd1", S_RD1, 32'hDEAD_BEEF);
        exp_v("nobypass_rd1", S_RD1NB, 32'd0); exp_v("rd2_zero", S_RD2, 32'd0);
        exp_v("ret_reset", S_RET, 32'd0);

        step(32'h8000_0000, 5'd3, 32'd2, 32'h12F4_5678, 32'd0, 32'd0, 32'd0, 5'd5, 5'd3, 1'b1);
        exp_v("lb_wd", S_WD, 32'hFFFF_FFF4); exp_v("lw_stored", S_RD1, 32'hDEAD_BEEF);
        exp_v("lw_stored_nb", S_RD1NB, 32'hDEAD_BEEF); exp_v("lb_rd2", S_RD2, 32'hFFFF_FFF4);
        exp_v("ret1", S_RET, 32'd1);

        step(32'h9000_0000, 5'd3, 32'd2, 32'h12F4_5678, 32'd0, 32'd0, 32'd0, 5'd3, 5'd3, 1'b1);
        exp_v("lbu_wd", S_WD, 32'h0000_00F4); exp_v("same_a_rd1", S_RD1, 32'h0000_00F4);
        exp_v("same_a_rd2", S_RD2, 32'h0000_00F4); exp_v("old_nb", S_RD1NB, 32'hFFFF_FFF4);
        exp_v("ret2", S_RET, 32'd2);

        step(32'h8400_0000, 5'd3, 32'd2, 32'h12F4_5678, 32'd0, 32'd0, 32'd0, 5'd3, 5'd3, 1'b1);
        exp_v("lh_wd", S_WD, 32'h0000_12F4); exp_v("lh_rd1", S_RD1, 32'h0000_12F4);
        exp_v("lbu_nb", S_RD1NB, 32'h0000_00F4); exp_v("ret3", S_RET, 32'd3);

        step(32'h8400_0000, 5'd6, 32'd3, 32'h8000_1234, 32'd0, 32'd0, 32'd0, 5'd3, 5'd0, 1'b1);
        exp_v("lh_off3_wd", S_WD, 32'hFFFF_8000); exp_v("lh_stored", S_RD1, 32'h0000_12F4);
        exp_v("ret4", S_RET, 32'd4);

        step(32'h9400_0000, 5'd7, 32'd0, 32'h1234_ABCD, 32'd0, 32'd0, 32'd0, 5'd6, 5'd0, 1'b1);
        exp_v("lhu_wd", S_WD, 32'h0000_ABCD); exp_v("r6", S_RD1, 32'hFFFF_8000);
        exp_v("ret5", S_RET, 32'd5); exp_v("ret_wrap", S_RETNB, 32'd1);

        step(32'h0C00_0C02, 5'd31, 32'h1111_1111, 32'h2222_2222, 32'd0, 32'd0, 32'h0000_3008, 5'd31, 5'd7, 1'b1);
        exp_v("jal_wd", S_WD, 32'h0000_3008); exp_v("jal_bypass", S_RD1, 32'h0000_3008);
        exp_v("jal_nobypass", S_RD1NB, 32'd0); exp_v("r7", S_RD2, 32'h0000_ABCD);
        exp_v("ret6", S_RET, 32'd6);

        step(32'h0000_F809, 5'd30, 32'h0000_0033, 32'd0, 32'd0, 32'd0, 32'h0000_0400, 5'd31, 5'd30, 1'b1);
        exp_v("jalr_wd", S_WD, 32'h0000_0400); exp_v("r31", S_RD1, 32'h0000_3008);
        exp_v("jalr_rd2", S_RD2, 32'h0000_0400); exp_v("ret7", S_RET, 32'd7);

        step(32'h0000_0021, 5'd0, 32'h0000_0055, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        exp_v("r0_we", S_WE, 32'd0); exp_v("r0_wa", S_WA, 32'd0);
        exp_v("addu_wd", S_WD, 32'h0000_0055); exp_v("r0_before", S_RD1, 32'd0);
        exp_v("r0_before_nb", S_RD1NB, 32'd0); exp_v("ret8", S_RET, 32'd8);

        step(32'h4008_6000, 5'd8, 32'h0000_0066, 32'd0, 32'd0, 32'h0000_A000, 32'd0, 5'd0, 5'd30, 1'b1);
        exp_v("mfc0_wd", S_WD, 32'h0000_A000); exp_v("r0_after", S_RD1, 32'd0);
        exp_v("r30", S_RD2, 32'h0000_0400); exp_v("ret9", S_RET, 32'd9);

        step(32'h0000_0012, 5'd9, 32'h0000_0066, 32'd0, 32'h0000_0007, 32'h0000_A000, 32'd0, 5'd8, 5'd0, 1'b1);
        exp_v("mflo_wd", S_WD, 32'h0000_0007); exp_v("r8", S_RD1, 32'h0000_A000);
        exp_v("ret10", S_RET, 32'd10);

        step(32'h0000_0010, 5'd10, 32'd0, 32'd0, 32'h0000_0099, 32'd0, 32'd0, 5'd9, 5'd8, 1'b1);
        exp_v("mfhi_wd", S_WD, 32'h0000_0099); exp_v("r9", S_RD1, 32'h0000_0007);
        exp_v("r8_p2", S_RD2, 32'h0000_A000); exp_v("ret11", S_RET, 32'd11);

        step(32'h4080_0000, 5'd11, 32'h0000_0077, 32'd0, 32'd0, 32'h0000_BBBB, 32'd0, 5'd10, 5'd0, 1'b1);
        exp_v("mtc0_alu", S_WD, 32'h0000_0077); exp_v("r10", S_RD1, 32'h0000_0099);
        exp_v("ret12", S_RET, 32'd12);

        step(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd11, 5'd0, 1'b1);
        exp_v("bub_we", S_WE, 32'd0); exp_v("r11", S_RD1, 32'h0000_0077);
        exp_v("ret13", S_RET, 32'd13);

        step(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        exp_v("bub_hold", S_RET, 32'd13);

        step(32'h0000_0021, 5'd4, 32'h0000_0011, 32'd0, 32'd0, 32'd0, 32'd0, 5'd4, 5'd5, 1'b0);
        exp_v("rst_we", S_WE, 32'd1); exp_v("rst_wd", S_WD, 32'h0000_0011);
        exp_v("rst_bypass", S_RD1, 32'h0000_0011); exp_v("rst_r5", S_RD2, 32'hDEAD_BEEF);
        exp_v("rst_ret", S_RET, 32'd13);

        step(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd4, 5'd5, 1'b1);
        exp_v("r4_dropped", S_RD1, 32'd0); exp_v("r5_cleared", S_RD2, 32'd0);
        exp_v("ret_cleared", S_RET, 32'd0); exp_v("retnb_cleared", S_RETNB, 32'd0);

        step(32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd31, 5'd9, 1'b1);
        exp_v("r31_cleared", S_RD1, 32'd0); exp_v("r9_cleared", S_RD2, 32'd0);
        exp_v("ret_bub_after_rst", S_RET, 32'd0);

        @(negedge Clk);
        #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
